// File: rtl/piso_pkg.sv
// Shared types and helpers for the LSB-first PISO serializer.
// Optional parity cycle is enabled by defining PISO_PARITY_EN.
package piso_pkg;

    localparam int unsigned PISO_DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    // Bits needed to count 0..n_values-1, never less than one.
    function automatic int unsigned piso_cnt_width(input int unsigned n_values);
        return (n_values <= 2) ? 1 : $clog2(n_values);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer: clear on (re)load, advance per
// emitted bit, saturate at TERMINAL and flag it.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned TERMINAL = 7,
    parameter int unsigned CW       = piso_cnt_width(TERMINAL + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] count_next,
    output logic          at_terminal
);

    localparam logic [CW-1:0] TERM_VAL = CW'(TERMINAL);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign at_terminal = (count_q == TERM_VAL);
    assign count_next  = count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (advance && !at_terminal) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_lsb_serializer.sv
// Parallel-in serial-out stage, LSB first, with valid/ready load and stall.
// Define PISO_PARITY_EN to append an even-parity bit after the MSB.
module piso_lsb_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = PISO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int unsigned LAST_IDX = WIDTH;
`else
    localparam int unsigned LAST_IDX = WIDTH - 1;
`endif
    localparam int unsigned   CW       = piso_cnt_width(LAST_IDX + 1);
    localparam logic [CW-1:0] LAST_VAL = CW'(LAST_IDX);

    piso_state_e      state_q;
    piso_state_e      state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic             ser_out_q;
    logic             ser_out_d;
    logic             ser_valid_q;
    logic             ser_valid_d;
    logic             frame_start_q;
    logic             frame_start_d;
    logic             frame_last_q;
    logic             frame_last_d;
    logic             load_ready_c;
    logic             load_xfer;
    logic             cnt_clear;
    logic             cnt_adv;
    logic [CW-1:0]    cnt_next;
    logic             cnt_at_last;
`ifdef PISO_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    piso_bit_counter #(
        .TERMINAL (LAST_IDX),
        .CW       (CW)
    ) u_bit_counter (
        .clk         (clk),
        .reset       (reset),
        .clear       (cnt_clear),
        .advance     (cnt_adv),
        .count_next  (cnt_next),
        .at_terminal (cnt_at_last)
    );

    always_comb begin
        load_ready_c = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE:    load_ready_c = 1'b1;
                SHIFT:   load_ready_c = cnt_at_last && ser_en;
                default: load_ready_c = 1'b0;
            endcase
        end
    end

    assign load_ready = load_ready_c;
    assign load_xfer  = load_valid && load_ready_c;

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_xfer) begin
                    state_d   = SHIFT;
                    sreg_d    = load_data;
                    cnt_clear = 1'b1;
                end
            end
            SHIFT: begin
                if (ser_en) begin
                    if (!cnt_at_last) begin
                        sreg_d  = sreg_q >> 1;
                        cnt_adv = 1'b1;
                    end else if (load_xfer) begin
                        sreg_d    = load_data;
                        cnt_clear = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PISO_PARITY_EN
    assign parity_d = load_xfer ? ^load_data : parity_q;
`endif

    // Outputs are registered from next-state values so they line up with the
    // bit position the counter will hold after this edge.
    always_comb begin
        ser_valid_d   = (state_d == SHIFT);
        ser_out_d     = 1'b0;
        frame_start_d = 1'b0;
        frame_last_d  = 1'b0;
        if (state_d == SHIFT) begin
            ser_out_d = sreg_d[0];
`ifdef PISO_PARITY_EN
            if (cnt_next == LAST_VAL) begin
                ser_out_d = parity_d;
            end
`endif
            frame_start_d = (cnt_next == '0);
            frame_last_d  = (cnt_next == LAST_VAL);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            sreg_q        <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_last_q  <= frame_last_d;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_last  = frame_last_q;
    assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_lsb_serializer.sv
// Self-checking bench for piso_lsb_serializer (WIDTH=8): directed table,
// corner sequences, downstream two's-complement chain and a queue model.
module tb_piso_lsb_serializer;

`ifdef PISO_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       ser_en;
    logic       ser_out;
    logic       ser_valid;
    logic       frame_start;
    logic       frame_last;
    logic       busy;

    int passed = 0;
    int total  = 0;

    piso_lsb_serializer #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .ser_en      (ser_en),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .frame_last  (frame_last),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        int         stall_at;   // bit index to stall on, 99 = final bit, -1 = none
        int         stall_len;
        logic [8:0] exp_bits;   // bit 8 is the parity bit
    } vec_t;

    typedef struct packed {
        logic b;
        logic s;
        logic l;
    } item_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_bit(input int k, input logic b);
        check($sformatf("bit%0d", k), {ser_valid, busy, ser_out, frame_start, frame_last},
              {2'b11, b, (k == 0), (k == FL - 1)});
    endtask

    task automatic check_idle(input string name);
        check(name, {ser_valid, busy, frame_start, frame_last, load_ready}, 5'b00001);
    endtask

    task automatic run_word(input logic [7:0] word, input int stall_at, input int stall_len,
                            input logic [8:0] exp);
        load_valid = 1'b1;
        load_data  = word;
        ser_en     = 1'b1;
        #1 check("ready_idle", load_ready, 1);
        step();
        load_valid = 1'b0;
        for (int k = 0; k < FL; k++) begin
            check_bit(k, exp[k]);
            if (k == stall_at) begin
                ser_en     = 1'b0;
                load_valid = (k == FL - 1);
                load_data  = 8'hC3;
                for (int s = 0; s < stall_len; s++) begin
                    #1 check("stall_ready", load_ready, 0);
                    step();
                    check_bit(k, exp[k]);
                end
                load_valid = 1'b0;
                ser_en     = 1'b1;
            end
            step();
        end
        check_idle("after_word");
    endtask

    vec_t  vecs[6];
    item_t q[$];

    initial begin
        logic [7:0] res;
        logic       seen;
        logic       exp_ready;
        int         idx;
        int         sa;
        logic [8:0] e0;
        logic [8:0] e1;
        logic [8:0] ea;

        vecs[0] = '{8'hB4, -1, 0, 9'h0B4};
        vecs[1] = '{8'h0F,  2, 3, 9'h00F};
        vecs[2] = '{8'h55, 99, 2, 9'h055};
        vecs[3] = '{8'h07, -1, 0, 9'h107};
        vecs[4] = '{8'h80,  0, 1, 9'h180};
        vecs[5] = '{8'hFF,  5, 2, 9'h0FF};

        reset      = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hA5;
        ser_en     = 1'b1;
        step();
        step();
        check("reset_outs", {ser_valid, busy, ser_out, frame_start, frame_last}, 5'b00000);
        check("reset_ready", load_ready, 0);
        load_valid = 1'b0;
        reset      = 1'b1;
        #1 check("ready_after_release", load_ready, 1);

        for (int i = 0; i < 6; i++) begin
            sa = (vecs[i].stall_at == 99) ? FL - 1 : vecs[i].stall_at;
            run_word(vecs[i].word, sa, vecs[i].stall_len, vecs[i].exp_bits);
        end

        // Back-to-back 8'h01 then 8'hFF with load_valid held.
        e0 = 9'h101;
        e1 = 9'h0FF;
        load_valid = 1'b1;
        load_data  = 8'h01;
        step();
        load_data = 8'hFF;
        for (int i = 0; i < 2 * FL; i++) begin
            check_bit(i % FL, (i < FL) ? e0[i % FL] : e1[i % FL]);
            if (i < FL) begin
                #1 check($sformatf("b2b_ready%0d", i), load_ready, (i == FL - 1));
            end
            step();
            if (i == FL - 1) load_valid = 1'b0;
        end
        check_idle("b2b_idle");

        // Reset in the middle of 8'hAA, then a clean 8'h55.
        ea = 9'h0AA;
        load_valid = 1'b1;
        load_data  = 8'hAA;
        step();
        load_valid = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            check_bit(k, ea[k]);
            if (k < 4) step();
        end
        reset = 1'b0;
        #1 check("ready_in_reset", load_ready, 0);
        step();
        check("midreset_outs", {ser_valid, busy, frame_start, frame_last}, 4'b0000);
        reset = 1'b1;
        run_word(8'h55, -1, 0, 9'h055);

        // Downstream chain: bit-serial two's complement restarted on frame_start.
        load_valid = 1'b1;
        load_data  = 8'h06;
        step();
        load_valid = 1'b0;
        res  = '0;
        seen = 1'b0;
        idx  = 0;
        for (int c = 0; c < FL + 2; c++) begin
            if (ser_valid) begin
                if (frame_start) begin
                    idx  = 0;
                    seen = 1'b0;
                end
                if (idx < 8) begin
                    res[idx] = seen ? ~ser_out : ser_out;
                    seen     = seen | ser_out;
                end
                idx++;
            end
            step();
        end
        check("chain_twos_comp", res, 8'hFA);

        // Randomized traffic against a queue-of-frame-items model.
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (q.size() == 0)
                check("rnd_idle", {ser_valid, busy}, 2'b00);
            else
                check("rnd_bit", {ser_valid, busy, ser_out, frame_start, frame_last},
                      {2'b11, q[0].b, q[0].s, q[0].l});
            ser_en     = ($urandom_range(0, 3) != 0);
            load_valid = ($urandom_range(0, 2) != 0);
            load_data  = 8'($urandom);
            #1;
            exp_ready = (q.size() == 0) || (q.size() == 1 && ser_en);
            check("rnd_ready", load_ready, exp_ready);
            if (ser_en && q.size() > 0) void'(q.pop_front());
            if (load_valid && exp_ready) begin
                for (int i = 0; i < 8; i++)
                    q.push_back('{b: load_data[i], s: (i == 0), l: (i == FL - 1)});
`ifdef PISO_PARITY_EN
                q.push_back('{b: ^load_data, s: 1'b0, l: 1'b1});
`endif
            end
            step();
        end
        load_valid = 1'b0;
        ser_en     = 1'b1;
        for (int cyc = 0; cyc < 2 * FL; cyc++) begin
            if (q.size() > 0) begin
                check("drain_bit", {ser_valid, busy, ser_out, frame_start, frame_last},
                      {2'b11, q[0].b, q[0].s, q[0].l});
                void'(q.pop_front());
            end
            step();
        end
        check_idle("drain_idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/piso_lsb_serializer.md
Name: piso_lsb_serializer

Overview:
- Parallel-in, serial-out stage sitting directly upstream of the bit-serial two's complement converter.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock, LSB first.
- Pulses frame_start on bit 0 so the downstream converter can be restarted per word; pulses frame_last on the final bit.
- Supports gapless back-to-back words and a downstream stall.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
load_valid  input  1  upstream word available
load_data  input  WIDTH  word to serialise
load_ready  output  1  stage can accept a word this cycle
ser_en  input  1  downstream advance enable; 0 = stall and hold all serial outputs
ser_out  output  1  current serial bit (LSB first)
ser_valid  output  1  ser_out carries a valid bit
frame_start  output  1  high with bit 0 of each word
frame_last  output  1  high with final bit of each word
busy  output  1  high while a word is in the shift register

Behaviour:
- Interface: one clock (clk); reset is synchronous, active-low, named reset.
- Reset (reset=0 at a clk edge):
  - state=IDLE; shift register and bit counter cleared.
  - ser_out=0, ser_valid=0, frame_start=0, frame_last=0, busy=0.
  - load_ready=0 while reset is low; load_ready=1 in the first cycle after release.
  - Reset mid-word aborts the word with no further bits emitted.
- All serial outputs are registered. load_ready is combinational from state, counter and ser_en.
- Handshake: a word transfers on any edge where load_valid && load_ready. load_data is sampled only then.
- States:
  - IDLE:
    - load_ready=1, ser_valid=0.
    - On transfer: capture word, count=0, go to SHIFT.
  - SHIFT:
    - ser_valid=1, ser_out=sreg[0].
    - frame_start=1 when count==0; frame_last=1 when count==WIDTH-1.
    - On edge with ser_en=1 and count<WIDTH-1: shift sreg right by 1, count+1.
    - On edge with ser_en=1 and count==WIDTH-1: on transfer, reload with the new word, count=0, stay in SHIFT; otherwise go to IDLE.
    - ser_en=0: hold sreg, count and all outputs.
- load_ready in SHIFT equals (count==WIDTH-1 && ser_en), so streaming is gapless.
- Latency: word accepted at edge T → bit 0 visible in cycle T+1; bit k in cycle T+1+k (no stalls).
- Counter width is $clog2(WIDTH); it never exceeds WIDTH-1 and wraps to 0 only on reload.
- Simultaneous final bit, ser_en=0 and load_valid=1: no transfer, because load_ready=0.
- busy=1 exactly when state==SHIFT.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - One extra cycle is appended after the MSB, carrying even parity (XOR of all WIDTH data bits).
  - frame_last moves to the parity cycle.
  - load_ready is asserted in the parity cycle instead of the MSB cycle.
  - Frame length is WIDTH+1.
- Undefined: frame length is WIDTH and no parity logic is present.

Decomposition:
- Shared package piso_pkg: state enum (IDLE, SHIFT), default WIDTH constant, and a counter-width function wrapping $clog2.
- One natural sub-module: piso_bit_counter.
  - Enabled counter with clear/reload and terminal-count output.
  - Terminal value WIDTH-1, or WIDTH when PISO_PARITY_EN is defined.
  - Used for frame_last and load_ready generation.

Test Plan:
- Reset then single word: load 8'hB4, ser_en=1 → ser_out 0,0,1,0,1,1,0,1 over 8 cycles starting the cycle after accept; frame_start on the 1st bit, frame_last on the 8th; then IDLE with busy=0.
- Back-to-back: 8'h01 then 8'hFF with load_valid held → 16 consecutive valid bits 1,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1; frame_start on cycles 1 and 9.
- Stall: 8'h0F, drop ser_en for 3 cycles after bit 2 → bit 2 (value 1) held for 4 cycles; bits resume in order; no transfer accepted during the stall at the final bit.
- Reset mid-word: 8'hAA, assert reset at bit 4 → next cycle ser_valid=0 and busy=0; following word 8'h55 emits correctly from bit 0.
- Downstream chain: feed 8'h06 through the two's-complement converter, restarted on frame_start → collected result 8'hFA.
- PISO_PARITY_EN: 8'h07 → 9 bits 1,1,1,0,0,0,0,0,1; frame_last on the parity bit.
